// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Sends in-order word fetches to a variable-latency instruction memory and
// buffers the returned words, together with their addresses, in a
// DEPTH-entry FIFO that decode drains through a valid/ready handshake.
// A redirect flushes the FIFO, restarts fetching at the new address, and
// discards every response that belongs to a request issued before it.
//
// Ports
//   clk_i, reset_ni               clock, asynchronous active-low reset
//   fetch_en_i                    allow new fetch requests
//   req_valid_o/req_ready_i       fetch request handshake
//   req_addr_o                    fetch word address
//   resp_valid_i/resp_data_i      in-order memory response
//   instr_valid_o/instr_ready_i   decode handshake on the FIFO head
//   instr_o, pc_o                 head instruction and its address
//   redirect_i, redirect_pc_i     flush and restart at redirect_pc_i
//
// state   | meaning
// S_IDLE  | no requests issued; waits for fetch_en_i
// S_FETCH | issuing requests while room in FIFO + in-flight budget
module fetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0001_0000
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            fetch_en_i,
   output logic            req_valid_o,
   input  logic            req_ready_i,
   output logic [XLEN-1:0] req_addr_o,
   input  logic            resp_valid_i,
   input  logic [XLEN-1:0] resp_data_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   typedef enum logic {S_IDLE, S_FETCH} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic            pending_q, pending_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   if_rd_q, if_rd_d, if_wr_q, if_wr_d;
   logic [XLEN-1:0] data_q [DEPTH];
   logic [XLEN-1:0] data_d [DEPTH];
   logic [XLEN-1:0] pc_q [DEPTH];
   logic [XLEN-1:0] pc_d [DEPTH];
   logic [XLEN-1:0] if_pc_q [DEPTH];
   logic [XLEN-1:0] if_pc_d [DEPTH];

   logic            room;
   logic            accept;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] redir_pc;

   // Buffered plus in-flight words never exceed DEPTH, so a response
   // always finds a free FIFO slot.
   assign room = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH);

   // Once a request is presented it stays up until accepted, even if
   // fetch_en_i falls meanwhile; only a redirect may withdraw it.
   assign req_valid_o   = (state_q == S_FETCH) && !redirect_i && room
                          && (fetch_en_i || pending_q);
   assign req_addr_o    = fetch_pc_q;
   assign accept        = req_valid_o && req_ready_i;
   assign redir_pc      = redirect_pc_i & ~XLEN'(3);

   // Responses in the redirect cycle, or while stale responses remain,
   // belong to pre-redirect requests and are discarded.
   assign push          = resp_valid_i && (drop_q == '0) && !redirect_i;
   assign instr_valid_o = (count_q != '0);
   assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
   assign instr_o       = data_q[rd_ptr_q];
   assign pc_o          = pc_q[rd_ptr_q];

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(resp_valid_i);
      drop_d        = drop_q;
      pending_d     = req_valid_o && !req_ready_i;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      if_rd_d       = if_rd_q;
      if_wr_d       = if_wr_q;
      data_d        = data_q;
      pc_d          = pc_q;
      if_pc_d       = if_pc_q;

      case (state_q)
         S_IDLE:  if (fetch_en_i) state_d = S_FETCH;
         S_FETCH: if (!fetch_en_i && !(req_valid_o && !req_ready_i)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         if_pc_d[if_wr_q] = fetch_pc_q;
         if_wr_d          = if_wr_q + PW'(1);
         fetch_pc_d       = fetch_pc_q + XLEN'(4);
      end

      // The in-flight PC queue pops on every response, dropped or not, so
      // it stays aligned with the memory's response order.
      if (resp_valid_i) begin
         if_rd_d = if_rd_q + PW'(1);
      end

      if (push) begin
         data_d[wr_ptr_q] = resp_data_i;
         pc_d[wr_ptr_q]   = if_pc_q[if_rd_q];
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      if (redirect_i) begin
         fetch_pc_d = redir_pc;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // Every request still in flight after this edge is stale.
         drop_d     = outstanding_q - CW'(resp_valid_i);
      end else begin
         count_d = count_q + CW'(push) - CW'(pop);
         if (resp_valid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         pending_q     <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         if_rd_q       <= '0;
         if_wr_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= '0;
            pc_q[i]    <= '0;
            if_pc_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         pending_q     <= pending_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         if_rd_q       <= if_rd_d;
         if_wr_q       <= if_wr_d;
         data_q        <= data_d;
         pc_q          <= pc_d;
         if_pc_q       <= if_pc_d;
      end
   end

   // A response with nothing in flight means the memory broke protocol.
   resp_without_request_a : assert property (@(posedge clk_i) disable iff (!reset_ni)
      resp_valid_i |-> (outstanding_q != '0));

endmodule
